// File: rtl/riscv_mem_pkg.sv
// Shared types for the fetch / load-store memory arbiter.
package riscv_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned MEM_WORDS  = 2 ** DEF_ADDR_W;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_id_t;

    // Request of the port currently selected by the picker.
    typedef struct packed {
        logic        we;
        logic [3:0]  wmask;
        logic [31:0] addr;
    } mem_req_t;

endpackage

// File: rtl/riscv_mem_arb_pick.sv
// Combinational winner selector; MEM_ARB_RR_EN switches fixed data priority to round-robin.
module riscv_mem_arb_pick
    import riscv_mem_pkg::*;
(
    input  logic     if_req,
    input  logic     d_req,
`ifdef MEM_ARB_RR_EN
    input  port_id_t last_grant,
`endif
    output port_id_t grant_id,
    output logic     grant_valid
);

    always_comb begin
        grant_valid = if_req | d_req;
        grant_id    = PORT_D;
`ifdef MEM_ARB_RR_EN
        // On a tie the port not served last wins.
        if (if_req && d_req) begin
            grant_id = (last_grant == PORT_D) ? PORT_IF : PORT_D;
        end else if (if_req) begin
            grant_id = PORT_IF;
        end
`else
        if (if_req && !d_req) begin
            grant_id = PORT_IF;
        end
`endif
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Serialises fetch and load/store accesses onto one synchronous word memory.
// Optional MEM_ARB_RR_EN: round-robin on simultaneous requests instead of data-first.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wmask,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    arb_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    port_id_t         owner, owner_d;
    logic [31:0]      if_rdata_d, d_rdata_d;
    logic             if_ack_d, d_ack_d;
    port_id_t         grant_id;
    logic             grant_valid;
    mem_req_t         sel;
    logic             unused_addr_bits;

`ifdef MEM_ARB_RR_EN
    port_id_t last_grant, last_grant_d;
`endif

    riscv_mem_arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
`ifdef MEM_ARB_RR_EN
        .last_grant  (last_grant),
`endif
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Request fields of the winning port.
    always_comb begin
        sel.we    = 1'b0;
        sel.wmask = 4'b0000;
        sel.addr  = if_addr;
        if (grant_id == PORT_D) begin
            sel.we    = d_we;
            sel.wmask = d_wmask;
            sel.addr  = d_addr;
        end
    end

    // Byte offset and bits beyond the memory size are dropped: accesses wrap.
    assign unused_addr_bits = ^{sel.addr[31:ADDR_W+2], sel.addr[1:0]};

    assign busy = (state != IDLE);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        owner_d    = owner;
        if_rdata_d = if_rdata;
        d_rdata_d  = d_rdata;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        mem_wmask  = 4'b0000;
        mem_wdata  = 32'h0;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant;
`endif
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    mem_en    = 1'b1;
                    mem_addr  = sel.addr[ADDR_W+1:2];
                    mem_wmask = sel.we ? sel.wmask : 4'b0000;
                    mem_wdata = d_wdata;
                    owner_d   = grant_id;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = grant_id;
`endif
                    if (sel.we) begin
                        state_d  = DONE;
                        if_ack_d = (grant_id == PORT_IF);
                        d_ack_d  = (grant_id == PORT_D);
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(RD_LAT - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_d  = DONE;
                    if_ack_d = (owner == PORT_IF);
                    d_ack_d  = (owner == PORT_D);
                    if (owner == PORT_IF) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // No memory strobe while reset is held, even with requests pending.
        if (!resetn) begin
            mem_en    = 1'b0;
            mem_addr  = '0;
            mem_wmask = 4'b0000;
            mem_wdata = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            owner    <= PORT_D;
            if_rdata <= 32'h0;
            d_rdata  <= 32'h0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant <= PORT_D;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            owner    <= owner_d;
            if_rdata <= if_rdata_d;
            d_rdata  <= d_rdata_d;
            if_ack   <= if_ack_d;
            d_ack    <= d_ack_d;
`ifdef MEM_ARB_RR_EN
            last_grant <= last_grant_d;
`endif
        end
    end

endmodule
